phase_a_unloader: RTL and testbench
===================================

# phase_a_unloader

Result serializer directly downstream of the phase A modular-reduction stage. It captures the full-width reduced operand `new_a` on the single-cycle `en_out` strobe and streams it out as `W`-bit words over a valid/ready interface, one word per accepted beat, with a last-word flag. It decouples the wide phase A datapath from narrow consumers such as the result FIFO or host bus. It also flags results lost because the unloader was still busy.

## Interface
- `Size`, 3072, operand width in bits; must be a multiple of `W`
- `W`, 64, output word width in bits
- `NWORDS`, `Size/W` (48), derived local parameter, words per result
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `new_a`  in  `Size`  reduced operand from phase A; valid only in the cycle `en_out`=1
- `en_out`  in  1  single-cycle result strobe from phase A
- `out_data`  out  `W`  current output word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts the word when `out_valid`&`out_ready`
- `out_last`  out  1  current word is word `NWORDS-1` of the result
- `out_idx`  out  6  index of the current word, 0..`NWORDS-1`
- `busy`  out  1  a captured result is not yet fully transferred
- `overflow`  out  1  sticky: a result strobe was dropped

## Operation
- Two states:
  - IDLE: `out_valid`=0, `busy`=0.
  - SEND: `out_valid`=1, `busy`=1.
- IDLE → SEND when `en_out`=1:
  - `new_a` is latched into the internal `Size`-bit shift/hold register.
  - Word counter is set to 0.
- SEND behaviour:
  - `out_data` = word `out_idx` of the held operand, with word k = bits `[k*W+W-1 : k*W]`.
  - `out_last` = (`out_idx` == `NWORDS-1`) & `out_valid`.
- Handshake (`out_valid`&`out_ready`):
  - Non-last word: counter increments by 1.
  - Last word: counter returns to 0 and state returns to IDLE, unless a new strobe arrives in the same cycle (see below).
- `out_ready`=0 stalls the transfer. `out_data`, `out_idx` and `out_last` hold stable, and `out_valid` stays 1. Valid is never withdrawn.
- `en_out`=1 in SEND:
  - In the same cycle as the last-word handshake: the new result is captured, the counter is set to 0, and the state stays SEND. This gives back-to-back results with no bubble.
  - Any other SEND cycle: the strobe is dropped, the held result is undisturbed, and `overflow` is set to 1.
- `overflow` clears only on `rst`.
- `out_data` is undefined/don't-care while `out_valid`=0. It is implemented as 0.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_idx`=0, `busy`=0, `overflow`=0, `out_data`=0, state IDLE.
- Reset takes effect at the next rising edge. If it lands mid-transfer, the held result is discarded and no further words are emitted.
- Latency:
  - `en_out` in cycle N gives `out_valid`=1 with word 0 in cycle N+1.
  - With `out_ready` held at 1, word k is presented in cycle N+1+k, and `out_last` is in cycle N+`NWORDS`.
- Minimum result spacing without overflow is `NWORDS` cycles, which is well below the phase A issue interval.
- `out_idx`, `out_last` and `out_data` are registered (or decoded from registered state only). There is no combinational path from `out_ready` to `out_valid` or `out_data`.
- `en_out` and `new_a` are sampled only on the strobe cycle. `new_a` changing in other cycles has no effect.

## Configuration
- `PHASE_A_UNLOAD_MSW_FIRST_EN`
  - Defined: words are emitted most-significant first, i.e. `out_idx` k carries bits `[Size-1-k*W -: W]`.
  - Undefined (default): words are emitted least-significant first, as above.
- `out_idx` and `out_last` numbering is identical in both builds: `out_idx` counts beats, 0 first.

## Test plan
- Reset, then `en_out` with `new_a` = {48 words, word k = 64'h0101_0101_0000_0000 + k}, `out_ready`=1:
  - 48 beats on consecutive cycles, word k on beat k.
  - `out_last` only on beat 47.
  - `busy` falls the cycle after beat 47.
- Same stimulus with `out_ready` toggling 1,0,1,0…:
  - Stalled cycles hold identical `out_data` and `out_idx`.
  - All 48 words are delivered in order with no duplicates.
- Second `en_out` (operand all 64'hFFFF_FFFF_FFFF_FFFF words) in the same cycle as the beat-47 handshake:
  - Next cycle shows word 0 = all-ones, `out_valid` stays 1 throughout, `overflow`=0.
- Second `en_out` at beat 10:
  - First result completes unchanged, `overflow`=1 from the next cycle and stays 1 until `rst`.
  - No second result is emitted.
- `rst` asserted at beat 20: next cycle `out_valid`=0, `out_idx`=0, `busy`=0, `overflow`=0; a fresh `en_out` restarts from word 0.
- Build with `PHASE_A_UNLOAD_MSW_FIRST_EN` using the first stimulus: beat 0 = 64'h0101_0101_0000_002F, beat 47 = 64'h0101_0101_0000_0000 with `out_last`=1.

Source files
------------

// File: rtl/phase_a_unloader.sv
// phase_a_unloader
// Result serializer behind the phase A modular-reduction stage. A full-width
// reduced operand is captured on the single-cycle en_out strobe and streamed
// out as W-bit words over a valid/ready handshake, with a last-word flag.
// A strobe that arrives while a result is still being transferred is dropped
// and recorded in the sticky overflow flag.
//
// Build option:
//   PHASE_A_UNLOAD_MSW_FIRST_EN  defined   -> most-significant word first
//                                undefined -> least-significant word first
// Beat numbering on out_idx/out_last is the same in both builds.

module phase_a_unloader #(
  parameter int Size = 3072,
  parameter int W    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [Size-1:0] new_a,
  input  logic            en_out,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [5:0]      out_idx,
  output logic            busy,
  output logic            overflow
);

  localparam int         NWORDS   = Size / W;
  localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [Size-1:0] hold_q, hold_d;
  logic            ovf_q, ovf_d;

  logic            at_last;
  logic [Size-1:0] hold_shifted;
  logic [W-1:0]    head_word;

  // The word being presented always sits at one end of the hold register;
  // each accepted beat shifts the next word into that position.
`ifdef PHASE_A_UNLOAD_MSW_FIRST_EN
  assign hold_shifted = hold_q << W;
  assign head_word    = hold_q[Size-1 -: W];
`else
  assign hold_shifted = hold_q >> W;
  assign head_word    = hold_q[W-1:0];
`endif

  assign at_last = (idx_q == LAST_IDX);

  // Next-state logic: capture, beat advance, back-to-back reload and overflow.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (en_out) begin
          state_d = SEND;
          idx_d   = 6'd0;
          hold_d  = new_a;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last) begin
            // Final beat accepted: a coincident strobe reloads with no bubble.
            if (en_out) begin
              state_d = SEND;
              idx_d   = 6'd0;
              hold_d  = new_a;
            end else begin
              state_d = IDLE;
              idx_d   = 6'd0;
              hold_d  = hold_shifted;
            end
          end else begin
            idx_d  = idx_q + 6'd1;
            hold_d = hold_shifted;
            if (en_out) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_q;
            end
          end
        end else begin
          // Stalled: everything holds, but a strobe here is still lost.
          if (en_out) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 6'd0;
        hold_d  = '0;
        ovf_d   = ovf_q;
      end
    endcase
  end

  // State, counter, operand and sticky flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded from registered state only; data is forced to 0 when idle.
  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_idx   = idx_q;
    overflow  = ovf_q;
    if (state_q == SEND) begin
      out_data = head_word;
      out_last = at_last;
    end else begin
      out_data = '0;
      out_last = 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_a_unloader.sv
// Directed bench for phase_a_unloader: full-rate streaming, ready toggling,
// back-to-back reload, dropped strobe / overflow, mid-transfer reset.
// Expected words are computed here from the stimulus patterns; define
// PHASE_A_UNLOAD_MSW_FIRST_EN to check the reversed word order.

module tb_phase_a_unloader;

  localparam int SIZE = 3072;
  localparam int W    = 64;
  localparam int NW   = 48;

  logic            clk = 1'b0;
  logic            rst;
  logic [SIZE-1:0] new_a;
  logic            en_out;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [5:0]      out_idx;
  logic            busy;
  logic            overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_ones;

  phase_a_unloader #(.Size(SIZE), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .new_a    (new_a),
    .en_out   (en_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_idx  (out_idx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // sel 0: word j = 0101_0101_0000_0000 + j ; sel 1: all ones
  function automatic logic [63:0] exp_word(input int sel, input int k);
    int j;
`ifdef PHASE_A_UNLOAD_MSW_FIRST_EN
    j = NW - 1 - k;
`else
    j = k;
`endif
    if (sel == 1) return 64'hFFFF_FFFF_FFFF_FFFF;
    else          return 64'h0101_0101_0000_0000 + 64'(j);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input int sel, input int k);
    chk("valid", 64'(out_valid), 64'd1);
    chk("busy",  64'(busy),      64'd1);
    chk("idx",   64'(out_idx),   64'(k));
    chk("data",  out_data,       exp_word(sel, k));
    chk("last",  64'(out_last),  64'(k == NW - 1));
  endtask

  task automatic start(input logic [SIZE-1:0] op);
    en_out = 1'b1;
    new_a  = op;
    tick();
    en_out = 1'b0;
    new_a  = {96{32'hDEAD_BEEF}};
  endtask

  task automatic check_idle(input string tag, input logic exp_ovf);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
    chk({tag, "_idx"},   64'(out_idx),   64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_data"},  out_data,       64'd0);
    chk({tag, "_ovf"},   64'(overflow),  64'(exp_ovf));
  endtask

  initial begin
    int k;
    for (int j = 0; j < NW; j++) begin
      op_a[j*W +: W] = 64'h0101_0101_0000_0000 + 64'(j);
    end
    op_ones   = '1;
    rst       = 1'b1;
    en_out    = 1'b0;
    new_a     = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    check_idle("reset", 1'b0);
    rst = 1'b0;
    tick();

    // 1: full-rate stream
    start(op_a);
    for (int b = 0; b < NW; b++) begin
      check_beat(0, b);
      tick();
    end
    check_idle("t1_end", 1'b0);

    // 2: out_ready toggling 1,0,1,0...
    start(op_a);
    k = 0;
    for (int cyc = 0; cyc < 200 && k < NW; cyc++) begin
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_idx",   64'(out_idx),   64'(k));
      chk("t2_data",  out_data,       exp_word(0, k));
      if (cyc % 2 == 0) begin
        out_ready = 1'b1;
        k++;
      end else begin
        out_ready = 1'b0;
      end
      tick();
    end
    chk("t2_done", 64'(k), 64'(NW));
    out_ready = 1'b1;
    check_idle("t2_end", 1'b0);

    // 3: new strobe coincident with last-word handshake
    start(op_a);
    for (int b = 0; b < NW - 1; b++) begin
      check_beat(0, b);
      tick();
    end
    check_beat(0, NW - 1);
    en_out = 1'b1;
    new_a  = op_ones;
    tick();
    en_out = 1'b0;
    new_a  = '0;
    for (int b = 0; b < NW; b++) begin
      check_beat(1, b);
      chk("t3_ovf", 64'(overflow), 64'd0);
      tick();
    end
    check_idle("t3_end", 1'b0);

    // 4: strobe at beat 10 is dropped and sets overflow
    start(op_a);
    for (int b = 0; b < NW; b++) begin
      check_beat(0, b);
      if (b == 10) begin
        en_out = 1'b1;
        new_a  = op_ones;
      end
      tick();
      en_out = 1'b0;
      chk("t4_ovf", 64'(overflow), 64'(b >= 10));
    end
    for (int c = 0; c < 4; c++) begin
      check_idle("t4_idle", 1'b1);
      tick();
    end

    // 5: reset at beat 20, then fresh transfer
    start(op_a);
    for (int b = 0; b < 20; b++) begin
      check_beat(0, b);
      tick();
    end
    check_beat(0, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t5_rst", 1'b0);
    tick();
    check_idle("t5_rst2", 1'b0);
    start(op_a);
    for (int b = 0; b < NW; b++) begin
      check_beat(0, b);
      tick();
    end
    check_idle("t5_end", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
